// File: rtl/fft4_input_framer.sv
// Ping-pong input framer for the 4-point FFT: packs four serial complex samples
// into one parallel frame, collecting into one bank while the other is held.
module fft4_input_framer #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_re_i,
  input  logic [W-1:0] in_im_i,
  input  logic         flush_i,
  output logic [W-1:0] x0_re_o,
  output logic [W-1:0] x0_im_o,
  output logic [W-1:0] x1_re_o,
  output logic [W-1:0] x1_im_o,
  output logic [W-1:0] x2_re_o,
  output logic [W-1:0] x2_im_o,
  output logic [W-1:0] x3_re_o,
  output logic [W-1:0] x3_im_o,
  output logic         frame_valid_o,
  input  logic         frame_ready_i,
  output logic [7:0]   frame_cnt_o
);

  localparam int unsigned NB = 2;
  localparam int unsigned NS = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned CW = 8;

  logic [NB-1:0][NS-1:0][W-1:0] re_q, re_d, im_q, im_d;
  logic [NB-1:0]                full_q, full_d;
  logic                         wr_bank_q, wr_bank_d;
  logic                         rd_bank_q, rd_bank_d;
  logic [IW-1:0]                wr_idx_q, wr_idx_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [NS-1:0][W-1:0]         xre_q, xre_d, xim_q, xim_d;
  logic                         in_ready_q, in_ready_d;
  logic                         frame_valid_q, frame_valid_d;
  logic                         accept_c, handoff_c;

  // Next-state: hand-off and write completion always touch different banks.
  always_comb begin
    re_d      = re_q;
    im_d      = im_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    cnt_d     = cnt_q;

    accept_c  = in_valid_i && !full_q[wr_bank_q];
    handoff_c = full_q[rd_bank_q] && frame_ready_i;

    if (handoff_c) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      cnt_d             = cnt_q + CW'(1);
    end

    if (flush_i) begin
      wr_idx_d = '0;
    end else if (accept_c) begin
      re_d[wr_bank_q][wr_idx_q] = in_re_i;
      im_d[wr_bank_q][wr_idx_q] = in_im_i;
      if (wr_idx_q == IW'(NS - 1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = wr_idx_q + IW'(1);
      end
    end

    // Outputs are registered copies of what the next state will present.
    in_ready_d    = !full_d[wr_bank_d];
    frame_valid_d = full_d[rd_bank_d];
    xre_d         = re_d[rd_bank_d];
    xim_d         = im_d[rd_bank_d];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      re_q          <= '0;
      im_q          <= '0;
      full_q        <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_idx_q      <= '0;
      cnt_q         <= '0;
      xre_q         <= '0;
      xim_q         <= '0;
      in_ready_q    <= 1'b1;
      frame_valid_q <= 1'b0;
    end else begin
      re_q          <= re_d;
      im_q          <= im_d;
      full_q        <= full_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wr_idx_q      <= wr_idx_d;
      cnt_q         <= cnt_d;
      xre_q         <= xre_d;
      xim_q         <= xim_d;
      in_ready_q    <= in_ready_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign in_ready_o    = in_ready_q;
  assign frame_valid_o = frame_valid_q;
  assign frame_cnt_o   = cnt_q;
  assign x0_re_o       = xre_q[0];
  assign x0_im_o       = xim_q[0];
  assign x1_re_o       = xre_q[1];
  assign x1_im_o       = xim_q[1];
  assign x2_re_o       = xre_q[2];
  assign x2_im_o       = xim_q[2];
  assign x3_re_o       = xre_q[3];
  assign x3_im_o       = xim_q[3];

endmodule
